// File: rtl/eth_rx2.sv
`default_nettype none
// ============================================================================
// Module   : eth_rx2
// Brief    : Manchester 10BASE-T frame receiver with byte buffer, done/ack
//            handshake and drop counter. Optional FCS check: ETH_RX2_CRC_EN.
// Revision : 1.0 - initial release
// ============================================================================
module eth_rx2 #(
    parameter int SPB    = 4,
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clk_en,
    input  logic              rx,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [7:0]        rd_data,
    output logic              rx_done,
    output logic [ADDR_W:0]   rx_len,
    output logic              rx_ovf,
    input  logic              rx_ack,
    output logic [7:0]        rx_drop,
    output logic              rx_crc_ok,
    output logic              rx_led
);

    localparam int                 c_GAP_W   = $clog2(2*SPB+2);
    localparam logic [c_GAP_W-1:0] c_GAP_MID = c_GAP_W'(3*SPB/4);
    localparam logic [c_GAP_W-1:0] c_GAP_SIL = c_GAP_W'(2*SPB);
    localparam logic [c_GAP_W-1:0] c_GAP_MAX = c_GAP_W'(2*SPB+1);

    localparam logic [2:0] c_IDLE  = 3'd0;
    localparam logic [2:0] c_PRE   = 3'd1;
    localparam logic [2:0] c_DATA  = 3'd2;
    localparam logic [2:0] c_HOLD  = 3'd3;
    localparam logic [2:0] c_DRAIN = 3'd4;

    logic               r_rx_meta, r_rx_sync, r_rx_smp;
    logic [c_GAP_W-1:0] r_gap;
    logic [2:0]         r_state;
    logic [7:0]         r_sr;
    logic [2:0]         r_bitcnt;
    logic [ADDR_W:0]    r_wr_ptr;
    logic               r_ovf_work, r_busy;
    logic               r_done, r_ovf, r_led;
    logic [ADDR_W:0]    r_len;
    logic [7:0]         r_drop, r_rd_data;
    logic [7:0]         r_mem [0:(1<<ADDR_W)-1];

    logic       w_edge, w_accept, w_silence, w_busy_now;
    logic       w_data_start, w_byte_done, w_wr_en, w_frame_end;
    logic [7:0] w_sr_next;

    assign w_edge       = clk_en && (r_rx_sync != r_rx_smp);
    assign w_accept     = w_edge && ((r_state == c_IDLE) || (r_gap >= c_GAP_MID));
    assign w_silence    = clk_en && !w_accept && (r_gap == c_GAP_SIL) && (r_state != c_IDLE);
    assign w_sr_next    = {r_rx_sync, r_sr[7:1]};
    assign w_data_start = (r_state == c_PRE) && w_accept && (w_sr_next == 8'hD5);
    assign w_byte_done  = (r_state == c_DATA) && w_accept && (r_bitcnt == 3'd7);
    assign w_wr_en      = w_byte_done && !r_wr_ptr[ADDR_W];
    assign w_frame_end  = (r_state == c_DATA) && w_silence && (r_wr_ptr != '0);
    assign w_busy_now   = w_accept || (r_busy && !w_silence);

    // Line sampling and mid-bit gap tracking
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rx_meta <= 1'b0;
            r_rx_sync <= 1'b0;
            r_rx_smp  <= 1'b0;
            r_gap     <= c_GAP_MAX;
        end else begin
            r_rx_meta <= rx;
            r_rx_sync <= r_rx_meta;
            if (clk_en) begin
                r_rx_smp <= r_rx_sync;
                if (w_accept)
                    r_gap <= '0;
                else if (r_gap != c_GAP_MAX)
                    r_gap <= r_gap + c_GAP_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= c_IDLE;
            r_sr       <= '0;
            r_bitcnt   <= '0;
            r_wr_ptr   <= '0;
            r_ovf_work <= 1'b0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_len      <= '0;
            r_ovf      <= 1'b0;
            r_drop     <= '0;
            r_led      <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                c_IDLE: begin
                    if (w_accept) begin
                        r_sr    <= {r_rx_sync, 7'd0};
                        r_state <= c_PRE;
                    end
                end
                c_PRE: begin
                    if (w_accept) begin
                        r_sr <= w_sr_next;
                        if (w_data_start) begin
                            r_state    <= c_DATA;
                            r_bitcnt   <= '0;
                            r_wr_ptr   <= '0;
                            r_ovf_work <= 1'b0;
                            r_led      <= 1'b1;
                        end
                    end else if (w_silence) begin
                        r_state <= c_IDLE;
                    end
                end
                c_DATA: begin
                    if (w_accept) begin
                        r_sr     <= w_sr_next;
                        r_bitcnt <= r_bitcnt + 3'd1;
                        if (w_wr_en)
                            r_wr_ptr <= r_wr_ptr + {{ADDR_W{1'b0}}, 1'b1};
                        else if (w_byte_done)
                            r_ovf_work <= 1'b1;
                    end else if (w_silence) begin
                        r_led <= 1'b0;
                        if (w_frame_end) begin
                            r_len   <= r_wr_ptr;
                            r_ovf   <= r_ovf_work;
                            r_done  <= 1'b1;
                            r_state <= c_HOLD;
                        end else begin
                            r_state <= c_IDLE;
                        end
                    end
                end
                c_HOLD: begin
                    // A frame arriving while held is tracked only to find its end
                    r_busy <= w_busy_now;
                    if (w_accept && !r_busy && (r_drop != 8'hFF))
                        r_drop <= r_drop + 8'd1;
                    if (rx_ack && !r_done)
                        r_state <= w_busy_now ? c_DRAIN : c_IDLE;
                end
                c_DRAIN: begin
                    if (w_silence) begin
                        r_busy  <= 1'b0;
                        r_state <= c_IDLE;
                    end
                end
                default: r_state <= c_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (w_wr_en && !rst)
            r_mem[r_wr_ptr[ADDR_W-1:0]] <= w_sr_next;
    end

    always_ff @(posedge clk) begin
        if (rst)
            r_rd_data <= '0;
        else
            r_rd_data <= r_mem[rd_addr];
    end

`ifdef ETH_RX2_CRC_EN
    localparam logic [31:0] c_POLY_REF = 32'hEDB88320;
    localparam logic [31:0] c_RESIDUE  = 32'hC704DD7B;

    logic [31:0] r_crc, w_crc_rev;
    logic        r_crc_ok;

    function automatic logic [31:0] crc_byte(input logic [31:0] crc, input logic [7:0] d);
        logic [31:0] c;
        c = crc ^ {24'd0, d};
        for (int i = 0; i < 8; i++)
            c = c[0] ? ((c >> 1) ^ c_POLY_REF) : (c >> 1);
        return c;
    endfunction

    // The register runs reflected; the residue constant is in MSB-first order
    always_comb begin
        w_crc_rev = '0;
        for (int i = 0; i < 32; i++)
            w_crc_rev[i] = r_crc[31-i];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_crc    <= '1;
            r_crc_ok <= 1'b0;
        end else begin
            if (w_data_start)
                r_crc <= '1;
            else if (w_byte_done)
                r_crc <= crc_byte(r_crc, w_sr_next);
            if (w_frame_end)
                r_crc_ok <= (w_crc_rev == c_RESIDUE);
        end
    end

    assign rx_crc_ok = r_crc_ok;
`else
    assign rx_crc_ok = 1'b1;
`endif

    assign rd_data = r_rd_data;
    assign rx_done = r_done;
    assign rx_len  = r_len;
    assign rx_ovf  = r_ovf;
    assign rx_drop = r_drop;
    assign rx_led  = r_led;

endmodule
`default_nettype wire

// File: tb/tb_eth_rx2.sv
`default_nettype none
// ============================================================================
// Module   : tb_eth_rx2
// Brief    : Self-checking bench for eth_rx2 (Manchester frame receiver).
// Revision : 1.0 - initial release
// ============================================================================
module tb_eth_rx2;

    localparam int SPB    = 4;
    localparam int ADDR_W = 8;

    logic              clk = 1'b0, rst = 1'b1, clk_en = 1'b0, rx = 1'b0, rx_ack = 1'b0;
    logic [ADDR_W-1:0] rd_addr = '0;
    logic [7:0]        rd_data, rx_drop;
    logic              rx_done, rx_ovf, rx_crc_ok, rx_led;
    logic [ADDR_W:0]   rx_len;

    int   n_chk = 0, n_fail = 0, done_cnt = 0;
    bit   abort_tx = 1'b0;
    logic [7:0] tx_q[$];
    logic [7:0] exp_mem[256];
    int   exp_len;
    bit   exp_ovf, exp_crc;

    typedef struct {
        int n;
        bit corrupt;
        int exp_len;
        bit exp_ovf;
        bit exp_crc;
    } vec_t;
    vec_t vt[5];

`ifdef ETH_RX2_CRC_EN
    localparam bit c_CRC_EN = 1'b1;
`else
    localparam bit c_CRC_EN = 1'b0;
`endif

    eth_rx2 #(.SPB(SPB), .ADDR_W(ADDR_W)) dut (
        .clk(clk), .rst(rst), .clk_en(clk_en), .rx(rx), .rd_addr(rd_addr),
        .rd_data(rd_data), .rx_done(rx_done), .rx_len(rx_len), .rx_ovf(rx_ovf),
        .rx_ack(rx_ack), .rx_drop(rx_drop), .rx_crc_ok(rx_crc_ok), .rx_led(rx_led)
    );

    always #5 clk = ~clk;

    initial forever begin
        @(negedge clk);
        clk_en = ~clk_en;
    end

    initial forever begin
        @(negedge clk);
        if (rx_done === 1'b1) done_cnt++;
    end

    initial begin
        #1_500_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Standard Ethernet FCS of the first n queued bytes
    function automatic logic [31:0] fcs_of(input int n);
        logic [31:0] c = 32'hFFFFFFFF;
        for (int i = 0; i < n; i++) begin
            c ^= {24'd0, tx_q[i]};
            for (int j = 0; j < 8; j++)
                c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
        end
        return ~c;
    endfunction

    task automatic build_frame(input int n, input bit corrupt, input bit rnd);
        logic [31:0] f;
        tx_q.delete();
        for (int i = 0; i < n; i++)
            tx_q.push_back(rnd ? 8'($urandom) : 8'(i));
        f = fcs_of(n);
        for (int i = 0; i < 4; i++)
            tx_q.push_back(f[8*i +: 8]);
        if (corrupt) tx_q[n] = tx_q[n] ^ 8'hFF;
    endtask

    task automatic set_expect(input int n);
        logic [31:0] f;
        exp_len = (n + 4 > 256) ? 256 : n + 4;
        exp_ovf = (n + 4 > 256);
        for (int i = 0; i < exp_len; i++) exp_mem[i] = tx_q[i];
        f = {tx_q[n+3], tx_q[n+2], tx_q[n+1], tx_q[n]};
        exp_crc = c_CRC_EN ? (f == fcs_of(n)) : 1'b1;
    endtask

    task automatic half_bit();
        repeat (SPB) @(negedge clk);
    endtask

    task automatic send_byte(input logic [7:0] v);
        for (int i = 0; i < 8; i++) begin
            if (!abort_tx) begin
                rx = ~v[i];
                half_bit();
            end
            if (!abort_tx) begin
                rx = v[i];
                half_bit();
            end
        end
        if (abort_tx) rx = 1'b0;
    endtask

    task automatic send_frame(input bit with_body);
        for (int i = 0; i < 7; i++) send_byte(8'h55);
        if (with_body) begin
            send_byte(8'hD5);
            foreach (tx_q[i]) send_byte(tx_q[i]);
        end
        rx = 1'b0;
    endtask

    task automatic wait_done(input int prev, input string name);
        int k = 0;
        while (done_cnt == prev && k < 400) begin
            @(negedge clk);
            k++;
        end
        repeat (40) @(negedge clk);
        chk(name, 32'(done_cnt - prev), 32'd1);
    endtask

    task automatic read_chk(input int a);
        @(negedge clk);
        rd_addr = 8'(a);
        @(negedge clk);
        chk($sformatf("rd[%0d]", a), 32'(rd_data), 32'(exp_mem[a]));
    endtask

    task automatic check_frame(input string name);
        chk({name, " len"}, 32'(rx_len), 32'(exp_len));
        chk({name, " ovf"}, 32'(rx_ovf), 32'(exp_ovf));
        chk({name, " crc"}, 32'(rx_crc_ok), 32'(exp_crc));
        chk({name, " led"}, 32'(rx_led), 32'd0);
        read_chk(0);
        read_chk(exp_len - 1);
        read_chk($urandom_range(exp_len - 1));
    endtask

    task automatic ack();
        @(negedge clk);
        rx_ack = 1'b1;
        @(negedge clk);
        rx_ack = 1'b0;
    endtask

    task automatic rx_frame(input int n, input bit corrupt, input bit rnd, input string name);
        int prev;
        build_frame(n, corrupt, rnd);
        set_expect(n);
        prev = done_cnt;
        send_frame(1'b1);
        wait_done(prev, {name, " done"});
        check_frame(name);
    endtask

    initial begin
        int prev;
        vt[0] = '{60,  1'b0, 64,  1'b0, 1'b1};
        vt[1] = '{60,  1'b1, 64,  1'b0, !c_CRC_EN};
        vt[2] = '{300, 1'b0, 256, 1'b1, 1'b1};
        vt[3] = '{252, 1'b0, 256, 1'b0, 1'b1};
        vt[4] = '{1,   1'b0, 5,   1'b0, 1'b1};

        repeat (3) @(negedge clk);
        chk("rst rd_data", 32'(rd_data), 32'd0);
        chk("rst done", 32'(rx_done), 32'd0);
        chk("rst len", 32'(rx_len), 32'd0);
        chk("rst ovf", 32'(rx_ovf), 32'd0);
        chk("rst drop", 32'(rx_drop), 32'd0);
        chk("rst led", 32'(rx_led), 32'd0);
        chk("rst crc", 32'(rx_crc_ok), 32'(!c_CRC_EN));
        rst = 1'b0;
        repeat (10) @(negedge clk);

        // Table-driven frames: normal, bad FCS, overflow, exact fill, minimum
        for (int t = 0; t < 5; t++) begin
            build_frame(vt[t].n, vt[t].corrupt, 1'b0);
            set_expect(vt[t].n);
            prev = done_cnt;
            send_frame(1'b1);
            wait_done(prev, $sformatf("vec%0d done", t));
            chk($sformatf("vec%0d len", t), 32'(rx_len), 32'(vt[t].exp_len));
            chk($sformatf("vec%0d ovf", t), 32'(rx_ovf), 32'(vt[t].exp_ovf));
            chk($sformatf("vec%0d crc", t), 32'(rx_crc_ok), 32'(vt[t].exp_crc));
            read_chk(vt[t].exp_len - 1);
            read_chk((vt[t].exp_len > 59) ? 59 : 0);
            ack();
        end

        // Frame arriving while the buffer is held is dropped
        rx_frame(40, 1'b0, 1'b1, "hold1");
        build_frame(20, 1'b0, 1'b1);
        prev = done_cnt;
        send_frame(1'b1);
        repeat (200) @(negedge clk);
        chk("hold no done", 32'(done_cnt - prev), 32'd0);
        chk("hold drop", 32'(rx_drop), 32'd1);
        chk("hold len", 32'(rx_len), 32'd44);
        read_chk(0);
        read_chk(43);
        read_chk(17);
        ack();
        rx_frame(25, 1'($urandom), 1'b1, "after ack");
        chk("after ack drop", 32'(rx_drop), 32'd1);

        // Ack during a dropped frame: that frame must stay dropped
        build_frame(30, 1'b0, 1'b1);
        prev = done_cnt;
        fork
            send_frame(1'b1);
            begin
                repeat (600) @(negedge clk);
                ack();
            end
        join
        repeat (200) @(negedge clk);
        chk("drain no done", 32'(done_cnt - prev), 32'd0);
        chk("drain drop", 32'(rx_drop), 32'd2);
        rx_frame(10, 1'b0, 1'b1, "post drain");
        ack();

        // Link pulse and runt preamble
        prev = done_cnt;
        @(negedge clk);
        rx = 1'b1;
        repeat (10) @(negedge clk);
        rx = 1'b0;
        repeat (100) @(negedge clk);
        chk("pulse no done", 32'(done_cnt - prev), 32'd0);
        chk("pulse drop", 32'(rx_drop), 32'd2);
        chk("pulse led", 32'(rx_led), 32'd0);
        send_frame(1'b0);
        repeat (100) @(negedge clk);
        chk("runt no done", 32'(done_cnt - prev), 32'd0);
        chk("runt drop", 32'(rx_drop), 32'd2);

        // Randomized frames against the model
        for (int r = 0; r < 3; r++) begin
            rx_frame($urandom_range(20, 1), 1'($urandom), 1'b1, $sformatf("rand%0d", r));
            ack();
        end

        // Reset at byte 20 of a frame
        build_frame(60, 1'b0, 1'b0);
        prev = done_cnt;
        fork
            send_frame(1'b1);
            begin
                repeat ((8 + 20) * 8 * 2 * SPB) @(negedge clk);
                chk("mid led", 32'(rx_led), 32'd1);
                rst = 1'b1;
                abort_tx = 1'b1;
                @(negedge clk);
                chk("mrst rd_data", 32'(rd_data), 32'd0);
                chk("mrst len", 32'(rx_len), 32'd0);
                chk("mrst drop", 32'(rx_drop), 32'd0);
                chk("mrst led", 32'(rx_led), 32'd0);
                chk("mrst done", 32'(rx_done), 32'd0);
                chk("mrst crc", 32'(rx_crc_ok), 32'(!c_CRC_EN));
                rst = 1'b0;
            end
        join
        repeat (200) @(negedge clk);
        chk("abort no done", 32'(done_cnt - prev), 32'd0);
        abort_tx = 1'b0;
        rx_frame(60, 1'b0, 1'b0, "post reset");
        chk("post reset drop", 32'(rx_drop), 32'd0);
        ack();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
